// File: rtl/apb_rr_bus_master_pkg.sv
// ============================================================================
// Module : apb_rr_bus_master_pkg
// Brief  : Shared APB widths, FSM state encoding and index-width helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package apb_rr_bus_master_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int PROT_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  // A single requester still needs a 1-bit index register.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_rr_bus_master_if.sv
// ============================================================================
// Module : apb_rr_bus_master_if
// Brief  : Requester-side handshake plus APB bus signals of the shared master.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface apb_rr_bus_master_if #(
  parameter int NREQ = 2,
  parameter int NSLV = 4
);
  import apb_rr_bus_master_pkg::*;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_write;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ*STRB_W-1:0] req_strb;
  logic [NREQ*PROT_W-1:0] req_prot;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   rsp_err;

  logic [ADDR_W-1:0]      paddr;
  logic                   pwrite;
  logic [DATA_W-1:0]      pwdata;
  logic [STRB_W-1:0]      pstrb;
  logic [PROT_W-1:0]      pprot;
  logic [NSLV-1:0]        psel;
  logic                   penable;
  logic [DATA_W-1:0]      prdata;
  logic                   pready;
  logic                   pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output paddr, pwrite, pwdata, pstrb, pprot, psel, penable,
    input  prdata, pready, pslverr
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, req_strb, req_prot,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  paddr, pwrite, pwdata, pstrb, pprot, psel, penable,
    output prdata, pready, pslverr
  );

endinterface

`default_nettype wire

// File: rtl/apb_rr_bus_master_arbiter.sv
// ============================================================================
// Module : apb_rr_bus_master_arbiter
// Brief  : Combinational round-robin pick: first valid request after ptr.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module apb_rr_bus_master_arbiter
  import apb_rr_bus_master_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = idx_width(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] gidx,
  output logic             gvalid
);

  always_comb begin : p_search
    int k;
    k      = 0;
    grant  = '0;
    gidx   = '0;
    gvalid = 1'b0;
    // Walk from the farthest candidate inward so the nearest one after ptr wins.
    for (int off = NREQ; off >= 1; off--) begin
      k = (int'(ptr) + off) % NREQ;
      if (req[k]) begin
        grant    = '0;
        grant[k] = 1'b1;
        gidx     = IDX_W'(k);
        gvalid   = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/apb_rr_bus_master.sv
// ============================================================================
// Module : apb_rr_bus_master
// Brief  : Round-robin shared APB master with decode-error and ACCESS timeout.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module apb_rr_bus_master
  import apb_rr_bus_master_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int NSLV    = 4,
  parameter int SEL_LSB = 28,
  parameter int TIMEOUT = 16
) (
  input  logic               pclk,
  input  logic               preset,
  apb_rr_bus_master_if.master bus
);

  localparam int IDX_W = idx_width(NREQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  apb_state_e        r_state;
  apb_state_e        w_next;
  logic [IDX_W-1:0]  r_ptr;
  logic [IDX_W-1:0]  r_gidx;
  logic [1:0]        r_sel;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_paddr;
  logic              r_pwrite;
  logic [DATA_W-1:0] r_pwdata;
  logic [STRB_W-1:0] r_pstrb;
  logic [PROT_W-1:0] r_pprot;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  logic [NREQ-1:0]   w_grant;
  logic [IDX_W-1:0]  w_gidx;
  logic              w_gvalid;
  logic [ADDR_W-1:0] w_gaddr;
  logic              w_gwrite;
  logic [DATA_W-1:0] w_gwdata;
  logic [STRB_W-1:0] w_gstrb;
  logic [PROT_W-1:0] w_gprot;
  logic [1:0]        w_gslv;
  logic              w_gdec_err;
  logic              w_timeout;

  apb_rr_bus_master_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req    (bus.req_valid),
    .ptr    (r_ptr),
    .grant  (w_grant),
    .gidx   (w_gidx),
    .gvalid (w_gvalid)
  );

  always_comb begin
    w_gaddr  = '0;
    w_gwrite = 1'b0;
    w_gwdata = '0;
    w_gstrb  = '0;
    w_gprot  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_gaddr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        w_gwrite = bus.req_write[i];
        w_gwdata = bus.req_wdata[i*DATA_W +: DATA_W];
        w_gstrb  = bus.req_strb[i*STRB_W +: STRB_W];
        w_gprot  = bus.req_prot[i*PROT_W +: PROT_W];
      end
    end
    w_gslv     = w_gaddr[SEL_LSB+1:SEL_LSB];
    w_gdec_err = (int'(w_gslv) >= NSLV);
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_timeout     = 1'b0;
    bus.req_ready = '0;
    bus.psel      = '0;
    bus.penable   = 1'b0;
    bus.rsp_valid = '0;
    case (r_state)
      ST_IDLE: begin
        bus.req_ready = w_grant;
        if (w_gvalid) w_next = w_gdec_err ? ST_RESP : ST_SETUP;
      end
      ST_SETUP: begin
        bus.psel = NSLV'(1) << r_sel;
        w_next   = ST_ACCESS;
      end
      ST_ACCESS: begin
        bus.psel    = NSLV'(1) << r_sel;
        bus.penable = 1'b1;
        // A pready landing on the final counted cycle still completes normally.
        if (bus.pready) begin
          w_next = ST_RESP;
        end else if (r_cnt == CNT_W'(TIMEOUT)) begin
          w_next    = ST_RESP;
          w_timeout = 1'b1;
        end
      end
      ST_RESP: begin
        bus.rsp_valid = NREQ'(1) << r_gidx;
        w_next        = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_ptr       <= IDX_W'(NREQ - 1);
      r_gidx      <= '0;
      r_sel       <= '0;
      r_cnt       <= '0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_pprot     <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gvalid) begin
            r_ptr       <= w_gidx;
            r_gidx      <= w_gidx;
            r_sel       <= w_gslv;
            r_paddr     <= w_gaddr;
            r_pwrite    <= w_gwrite;
            r_pwdata    <= w_gwdata;
            r_pstrb     <= w_gstrb;
            r_pprot     <= w_gprot;
            r_rsp_rdata <= '0;
            r_rsp_err   <= w_gdec_err;
          end
        end
        ST_SETUP: r_cnt <= CNT_W'(1);
        ST_ACCESS: begin
          if (bus.pready) begin
            r_rsp_err   <= bus.pslverr;
            r_rsp_rdata <= (!r_pwrite && !bus.pslverr) ? bus.prdata : '0;
          end else if (w_timeout) begin
            r_rsp_err   <= 1'b1;
            r_rsp_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.paddr     = r_paddr;
  assign bus.pwrite    = r_pwrite;
  assign bus.pwdata    = r_pwdata;
  assign bus.pstrb     = r_pstrb;
  assign bus.pprot     = r_pprot;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_apb_rr_bus_master.sv
// ============================================================================
// Module : tb_apb_rr_bus_master
// Brief  : Directed bench with a transaction-timeline model of the shared master.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_apb_rr_bus_master;
  import apb_rr_bus_master_pkg::*;

  localparam int NREQ    = 2;
  localparam int NSLV    = 3;
  localparam int SEL_LSB = 28;
  localparam int TIMEOUT = 16;

  logic pclk   = 1'b0;
  logic preset = 1'b1;
  always #5 pclk = ~pclk;

  apb_rr_bus_master_if #(.NREQ(NREQ), .NSLV(NSLV)) bus ();

  apb_rr_bus_master #(
    .NREQ(NREQ), .NSLV(NSLV), .SEL_LSB(SEL_LSB), .TIMEOUT(TIMEOUT)
  ) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  // Slave: pready tied high, or raised after slv_wait ACCESS cycles, or never.
  bit          slv_tie = 1'b1, slv_stuck = 1'b0, slv_err = 1'b0;
  int          slv_wait = 0, slv_cnt = 0;
  logic [31:0] slv_rdata = 32'h0;
  always @(posedge pclk) slv_cnt <= bus.penable ? slv_cnt + 1 : 0;
  assign bus.pready  = slv_tie || (!slv_stuck && bus.penable && slv_cnt >= slv_wait);
  assign bus.prdata  = slv_rdata;
  assign bus.pslverr = slv_err;

  int checks = 0, errors = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: each transfer is a timeline counted from its grant cycle.
  bit          m_busy = 1'b0, m_dec, m_wr, m_err;
  int          m_k, m_g, m_ptr = NREQ - 1, m_L, m_slv;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_strb;
  logic [2:0]  m_prot;

  // Observed history for the directed literal checks.
  int          ob_gcyc = 0, ob_rcyc = 0, ob_pen = 0;
  logic [31:0] ob_rdata = 0;
  logic        ob_err = 0;
  logic [NSLV-1:0] ob_psel_or = 0;
  int          grants[$];

  always @(negedge pclk) begin : p_compare
    logic [NREQ-1:0] e_ready, e_rv;
    logic [NSLV-1:0] e_psel;
    bit              e_pen, resp_now, grant_now, to;
    cyc++;
    if (preset) begin
      chk("rst_psel", 32'(bus.psel), 32'h0);
      chk("rst_penable", 32'(bus.penable), 32'h0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
      m_busy = 1'b0;
      m_ptr  = NREQ - 1;
    end else begin
      e_ready = '0; e_rv = '0; e_psel = '0; e_pen = 1'b0;
      resp_now = 1'b0; grant_now = 1'b0;
      if (!m_busy) begin
        for (int off = 1; off <= NREQ; off++) begin
          if (bus.req_valid[(m_ptr + off) % NREQ]) begin
            m_g = (m_ptr + off) % NREQ;
            grant_now = 1'b1;
            break;
          end
        end
        if (grant_now) begin
          e_ready[m_g] = 1'b1;
          m_wr    = bus.req_write[m_g];
          m_addr  = bus.req_addr[32*m_g +: 32];
          m_wdata = bus.req_wdata[32*m_g +: 32];
          m_strb  = bus.req_strb[4*m_g +: 4];
          m_prot  = bus.req_prot[3*m_g +: 3];
          m_slv   = int'(m_addr[SEL_LSB +: 2]);
          m_dec   = (m_slv >= NSLV);
          if (slv_tie) begin
            m_L = 1; to = 1'b0;
          end else if (slv_stuck || slv_wait + 1 > TIMEOUT) begin
            m_L = TIMEOUT; to = 1'b1;
          end else begin
            m_L = slv_wait + 1; to = 1'b0;
          end
          m_err   = m_dec || to || slv_err;
          m_rdata = (m_err || m_wr) ? 32'h0 : slv_rdata;
        end
      end else if (m_dec) begin
        if (m_k == 1) begin e_rv[m_g] = 1'b1; resp_now = 1'b1; end
      end else begin
        if (m_k == 1) begin
          e_psel[m_slv] = 1'b1;
        end else if (m_k <= 1 + m_L) begin
          e_psel[m_slv] = 1'b1; e_pen = 1'b1;
        end else begin
          e_rv[m_g] = 1'b1; resp_now = 1'b1;
        end
      end

      chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
      chk("psel", 32'(bus.psel), 32'(e_psel));
      chk("penable", 32'(bus.penable), 32'(e_pen));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_rv));
      if (e_psel != 0) begin
        chk("paddr", bus.paddr, m_addr);
        chk("pwrite", 32'(bus.pwrite), 32'(m_wr));
        chk("pwdata", bus.pwdata, m_wdata);
        chk("pstrb", 32'(bus.pstrb), 32'(m_strb));
        chk("pprot", 32'(bus.pprot), 32'(m_prot));
      end
      if (resp_now) begin
        chk("rsp_rdata", bus.rsp_rdata, m_rdata);
        chk("rsp_err", 32'(bus.rsp_err), 32'(m_err));
      end

      if (m_busy) begin
        if (resp_now) m_busy = 1'b0;
        else m_k++;
      end else if (grant_now) begin
        m_busy = 1'b1; m_k = 1; m_ptr = m_g;
      end

      if (bus.req_ready != 0) begin
        grants.push_back(bus.req_ready[1] ? 1 : 0);
        ob_gcyc = cyc; ob_pen = 0; ob_psel_or = '0;
      end
      if (bus.penable) ob_pen++;
      ob_psel_or |= bus.psel;
      if (bus.rsp_valid != 0) begin
        ob_rcyc = cyc; ob_rdata = bus.rsp_rdata; ob_err = bus.rsp_err;
      end
    end
  end

  task automatic set_req(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input logic [2:0] p);
    bus.req_write[i]        = wr;
    bus.req_addr[32*i +: 32] = a;
    bus.req_wdata[32*i +: 32] = d;
    bus.req_strb[4*i +: 4]  = s;
    bus.req_prot[3*i +: 3]  = p;
  endtask

  task automatic xfer(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p);
    bit ok;
    @(posedge pclk); #1;
    set_req(i, wr, a, d, s, p);
    bus.req_valid[i] = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge pclk);
      if (bus.req_ready[i]) ok = 1'b1;
    end
    @(posedge pclk); #1;
    bus.req_valid[i] = 1'b0;
    chk("grant_wait", 32'(ok), 32'h1);
    ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge pclk);
      if (bus.rsp_valid[i]) ok = 1'b1;
    end
    chk("rsp_wait", 32'(ok), 32'h1);
    @(posedge pclk); #1;
  endtask

  initial begin : p_stim
    bit ok;
    int nrsp;
    bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_strb = '0; bus.req_prot = '0;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_paddr", bus.paddr, 32'h0);
    chk("rst_pwdata", bus.pwdata, 32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
    preset = 1'b0;

    // Zero-wait write from requester 0 to slave 1.
    slv_tie = 1'b1;
    xfer(0, 1'b1, 32'h1000_0004, 32'h1234_5678, 4'hF, 3'b010);
    chk("t1_latency", 32'(ob_rcyc - ob_gcyc), 32'd3);
    chk("t1_err", 32'(ob_err), 32'h0);
    chk("t1_psel", 32'(ob_psel_or), 32'b010);
    chk("t1_penable_cycles", 32'(ob_pen), 32'd1);

    // Both requesters hold valid; grants must alternate starting after requester 0.
    grants.delete();
    slv_rdata = 32'h0BAD_F00D;
    @(posedge pclk); #1;
    set_req(0, 1'b1, 32'h0000_0010, 32'hA5A5_0000, 4'h3, 3'b000);
    set_req(1, 1'b0, 32'h1000_0020, 32'h0, 4'hF, 3'b101);
    bus.req_valid = 2'b11;
    nrsp = 0;
    for (int n = 0; n < 100 && nrsp < 8; n++) begin
      @(negedge pclk);
      if (bus.rsp_valid != 0) nrsp++;
    end
    @(posedge pclk); #1;
    bus.req_valid = '0;
    chk("t2_transfers", 32'(nrsp), 32'd8);
    repeat (2) @(posedge pclk); #1;
    chk("t2_ngrants", 32'(grants.size()), 32'd8);
    for (int i = 0; i < 8 && i < grants.size(); i++)
      chk($sformatf("t2_grant%0d", i), 32'(grants[i]), (i % 2 == 0) ? 32'd1 : 32'd0);

    // Read with three wait states.
    slv_tie = 1'b0; slv_wait = 3; slv_rdata = 32'hDEAD_BEEF;
    xfer(1, 1'b0, 32'h2000_0000, 32'h0, 4'hF, 3'b000);
    chk("t3_rdata", ob_rdata, 32'hDEAD_BEEF);
    chk("t3_penable_cycles", 32'(ob_pen), 32'd4);
    chk("t3_latency", 32'(ob_rcyc - ob_gcyc), 32'd6);
    chk("t3_psel", 32'(ob_psel_or), 32'b100);

    // Slave index 3 does not exist.
    slv_tie = 1'b1;
    xfer(0, 1'b0, 32'h3000_0000, 32'h0, 4'hF, 3'b000);
    chk("t4_latency", 32'(ob_rcyc - ob_gcyc), 32'd1);
    chk("t4_err", 32'(ob_err), 32'h1);
    chk("t4_psel", 32'(ob_psel_or), 32'h0);
    chk("t4_rdata", ob_rdata, 32'h0);

    // Hung slave: abort after TIMEOUT access cycles, then a normal transfer.
    slv_tie = 1'b0; slv_stuck = 1'b1;
    xfer(1, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 3'b000);
    chk("t5_latency", 32'(ob_rcyc - ob_gcyc), 32'd18);
    chk("t5_penable_cycles", 32'(ob_pen), 32'd16);
    chk("t5_err", 32'(ob_err), 32'h1);
    chk("t5_rdata", ob_rdata, 32'h0);
    slv_stuck = 1'b0; slv_tie = 1'b1;
    xfer(0, 1'b1, 32'h2000_0008, 32'hCAFE_0001, 4'h5, 3'b001);
    chk("t5_next_latency", 32'(ob_rcyc - ob_gcyc), 32'd3);
    chk("t5_next_err", 32'(ob_err), 32'h0);

    // pready on the last counted cycle completes; one later times out.
    slv_tie = 1'b0; slv_wait = 15; slv_rdata = 32'h5555_AAAA;
    xfer(1, 1'b0, 32'h1000_0000, 32'h0, 4'hF, 3'b000);
    chk("tb_edge_err", 32'(ob_err), 32'h0);
    chk("tb_edge_rdata", ob_rdata, 32'h5555_AAAA);
    chk("tb_edge_penable_cycles", 32'(ob_pen), 32'd16);
    slv_wait = 16;
    xfer(0, 1'b0, 32'h1000_0000, 32'h0, 4'hF, 3'b000);
    chk("tb_late_err", 32'(ob_err), 32'h1);
    chk("tb_late_latency", 32'(ob_rcyc - ob_gcyc), 32'd18);

    // Slave error on a read returns zero data.
    slv_tie = 1'b1; slv_err = 1'b1;
    xfer(1, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 3'b000);
    chk("tslv_err", 32'(ob_err), 32'h1);
    chk("tslv_rdata", ob_rdata, 32'h0);
    slv_err = 1'b0;

    // Reset during ACCESS.
    slv_tie = 1'b0; slv_stuck = 1'b1;
    @(posedge pclk); #1;
    set_req(1, 1'b0, 32'h0000_0200, 32'h0, 4'hF, 3'b000);
    bus.req_valid[1] = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge pclk);
      if (bus.req_ready[1]) ok = 1'b1;
    end
    chk("t6_grant_wait", 32'(ok), 32'h1);
    @(posedge pclk); #1;
    bus.req_valid = '0;
    repeat (3) @(posedge pclk);
    #2;
    chk("t6_penable_before", 32'(bus.penable), 32'h1);
    preset = 1'b1;
    #1;
    chk("t6_psel_now", 32'(bus.psel), 32'h0);
    chk("t6_penable_now", 32'(bus.penable), 32'h0);
    repeat (2) @(posedge pclk);
    #1;
    preset = 1'b0;
    slv_stuck = 1'b0; slv_tie = 1'b1;
    set_req(0, 1'b1, 32'h1000_0000, 32'h0000_00FF, 4'hF, 3'b000);
    bus.req_valid = 2'b11;
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge pclk);
      if (bus.req_ready != 0) ok = 1'b1;
    end
    chk("t6_first_grant", 32'(bus.req_ready), 32'b01);
    @(posedge pclk); #1;
    bus.req_valid = '0;
    repeat (6) @(posedge pclk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : p_watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

endmodule

`default_nettype wire
